// File: rtl/align_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : align_sequencer
// Brief    : Multi-cycle FP-adder operand alignment. Picks the larger-exponent
//            operand, clamps the exponent difference to a 6-bit shift amount
//            and right-shifts the smaller significand at most STEP bits per
//            cycle, collecting guard/round/sticky on the way.
// Revision : 1.0 - initial release
// ============================================================================
module align_sequencer #(
    parameter int EW    = 11,
    parameter int FW    = 53,
    parameter int STEP  = 8,
    parameter int SHMAX = 55
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [EW-1:0]   ea,
    input  logic [EW-1:0]   eb,
    input  logic [FW-1:0]   fa,
    input  logic [FW-1:0]   fb,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            swap,
    output logic [EW-1:0]   e_out,
    output logic [5:0]      shamt,
    output logic [FW+2:0]   f_big,
    output logic [FW+2:0]   f_small
);

    localparam int          c_ww        = FW + 3;
    localparam logic [5:0]  c_step      = 6'(STEP);
    localparam logic [5:0]  c_shmax     = 6'(SHMAX);
    localparam logic [EW:0] c_shmax_ext = (EW+1)'(SHMAX);

    localparam logic [1:0]  c_idle  = 2'd0;
    localparam logic [1:0]  c_setup = 2'd1;
    localparam logic [1:0]  c_shift = 2'd2;
    localparam logic [1:0]  c_done  = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;

    logic [EW-1:0]   r_ea;
    logic [EW-1:0]   r_eb;
    logic [FW-1:0]   r_fa;
    logic [FW-1:0]   r_fb;

    logic            r_swap;
    logic [EW-1:0]   r_e_out;
    logic [5:0]      r_shamt;
    logic [c_ww-1:0] r_f_big;
    logic [c_ww-1:0] r_w;
    logic [5:0]      r_rem;

    logic            w_swap;
    logic [EW:0]     w_diff;
    logic [5:0]      w_shamt;
    logic [5:0]      w_k;
    logic [5:0]      w_rem_next;
    logic [c_ww-1:0] w_shifted;
    logic [c_ww-1:0] w_mask;
    logic [c_ww-1:0] w_w_next;
    logic            w_accept;

    // SETUP arithmetic: operand ordering, widened difference and clamp
    always_comb begin
        w_swap  = (r_eb > r_ea);
        w_diff  = w_swap ? ({1'b0, r_eb} - {1'b0, r_ea})
                         : ({1'b0, r_ea} - {1'b0, r_eb});
        w_shamt = (w_diff > c_shmax_ext) ? c_shmax : w_diff[5:0];
    end

    // SHIFT step: bits k..0 of the old word all fold into the new sticky bit
    always_comb begin
        w_k        = (r_rem > c_step) ? c_step : r_rem;
        w_shifted  = r_w >> w_k;
        w_mask     = ~({c_ww{1'b1}} << (w_k + 6'd1));
        w_w_next   = {w_shifted[c_ww-1:1], |(r_w & w_mask)};
        w_rem_next = r_rem - w_k;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            c_idle: begin
                in_ready = !rst;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = c_setup;
                end
            end
            c_setup: begin
                w_next_state = (w_shamt == 6'd0) ? c_done : c_shift;
            end
            c_shift: begin
                if (w_rem_next == 6'd0) begin
                    w_next_state = c_done;
                end
            end
            c_done: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = c_idle;
                end
            end
            default: begin
                w_next_state = c_idle;
            end
        endcase
    end

    // Operand capture, SETUP load and iterative alignment datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ea    <= '0;
            r_eb    <= '0;
            r_fa    <= '0;
            r_fb    <= '0;
            r_swap  <= 1'b0;
            r_e_out <= '0;
            r_shamt <= '0;
            r_f_big <= '0;
            r_w     <= '0;
            r_rem   <= '0;
        end else begin
            if (w_accept) begin
                r_ea <= ea;
                r_eb <= eb;
                r_fa <= fa;
                r_fb <= fb;
            end
            if (r_state == c_setup) begin
                r_swap  <= w_swap;
                r_e_out <= w_swap ? r_eb : r_ea;
                r_shamt <= w_shamt;
                r_rem   <= w_shamt;
                r_f_big <= {(w_swap ? r_fb : r_fa), 3'b000};
                r_w     <= {(w_swap ? r_fa : r_fb), 3'b000};
            end
            if (r_state == c_shift) begin
                r_w   <= w_w_next;
                r_rem <= w_rem_next;
            end
        end
    end

    assign swap    = r_swap;
    assign e_out   = r_e_out;
    assign shamt   = r_shamt;
    assign f_big   = r_f_big;
    assign f_small = r_w;

endmodule
`default_nettype wire

// File: tb/tb_align_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_align_sequencer
// Brief    : Self-checking bench for align_sequencer. Expected results come
//            from a direct (non-iterative) alignment model and are queued at
//            operand acceptance, then popped when the result appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_align_sequencer;

    localparam int EW = 11;
    localparam int FW = 53;
    localparam int WW = FW + 3;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [EW-1:0] ea;
    logic [EW-1:0] eb;
    logic [FW-1:0] fa;
    logic [FW-1:0] fb;
    logic          out_valid;
    logic          out_ready;
    logic          swap;
    logic [EW-1:0] e_out;
    logic [5:0]    shamt;
    logic [WW-1:0] f_big;
    logic [WW-1:0] f_small;

    typedef struct {
        logic          swap;
        logic [EW-1:0] e_out;
        logic [5:0]    shamt;
        logic [WW-1:0] f_big;
        logic [WW-1:0] f_small;
        int            lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    align_sequencer #(.EW(EW), .FW(FW), .STEP(8), .SHMAX(55)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ea        (ea),
        .eb        (eb),
        .fa        (fa),
        .fb        (fb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .swap      (swap),
        .e_out     (e_out),
        .shamt     (shamt),
        .f_big     (f_big),
        .f_small   (f_small)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Direct reference: X >> shamt with bit 0 replaced by OR(X[shamt:0])
    function automatic exp_t model(input logic [EW-1:0] a, input logic [EW-1:0] b,
                                   input logic [FW-1:0] pa, input logic [FW-1:0] pb);
        exp_t          r;
        int            d;
        logic [WW-1:0] x;
        logic          s;
        r.swap  = (b > a);
        r.e_out = r.swap ? b : a;
        d       = r.swap ? (int'(b) - int'(a)) : (int'(a) - int'(b));
        if (d > 55) d = 55;
        r.shamt = 6'(d);
        r.f_big = {(r.swap ? pb : pa), 3'b000};
        x       = {(r.swap ? pa : pb), 3'b000};
        s       = 1'b0;
        for (int i = 0; i <= d; i++) s = s | x[i];
        r.f_small    = x >> d;
        r.f_small[0] = s;
        r.lat        = 2 + (d + 7) / 8;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands, wait (bounded) for in_ready, and queue the expectation
    task automatic accept(input logic [EW-1:0] a, input logic [EW-1:0] b,
                          input logic [FW-1:0] pa, input logic [FW-1:0] pb);
        int t = 0;
        ea = a; eb = b; fa = pa; fb = pb;
        in_valid = 1'b1;
        while (!in_ready && t < 50) begin
            tick();
            t++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
        end else begin
            tick();
            sb_q.push_back(model(a, b, pa, pb));
        end
        in_valid = 1'b0;
    endtask

    // Wait for the result (cycle 1 = SETUP), compare against the queue, then release it
    task automatic collect(input string tag);
        int   c = 1;
        exp_t e;
        while (!out_valid && c < 20) begin
            tick();
            c++;
        end
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s out_valid_timeout: out_valid=%b required 1", tag, out_valid);
            return;
        end
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s scoreboard_empty: got result, required none", tag);
            return;
        end
        e = sb_q.pop_front();
        n_checks++;
        if (c !== e.lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d required %0d", tag, c, e.lat);
        end
        n_checks++;
        if (swap !== e.swap) begin
            n_fail++;
            $display("FAIL %s swap: got %b required %b", tag, swap, e.swap);
        end
        n_checks++;
        if (e_out !== e.e_out) begin
            n_fail++;
            $display("FAIL %s e_out: got %h required %h", tag, e_out, e.e_out);
        end
        n_checks++;
        if (shamt !== e.shamt) begin
            n_fail++;
            $display("FAIL %s shamt: got %0d required %0d", tag, shamt, e.shamt);
        end
        n_checks++;
        if (f_big !== e.f_big) begin
            n_fail++;
            $display("FAIL %s f_big: got %h required %h", tag, f_big, e.f_big);
        end
        n_checks++;
        if (f_small !== e.f_small) begin
            n_fail++;
            $display("FAIL %s f_small: got %h required %h", tag, f_small, e.f_small);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s release: in_ready=%b out_valid=%b required 1 0", tag, in_ready, out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b required 0 0", in_ready, out_valid);
        end
        n_checks++;
        if (swap !== 1'b0 || e_out !== '0 || shamt !== '0 || f_big !== '0 || f_small !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: swap=%b e_out=%h shamt=%0d f_big=%h f_small=%h required all 0",
                     swap, e_out, shamt, f_big, f_small);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_reset_mid_shift();
        int seen = 0;
        accept(11'h7FE, 11'h001, 53'h10_0000_0000_0000, 53'h1F_FFFF_FFFF_FFFF);
        if (sb_q.size() > 0) void'(sb_q.pop_back());
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_in_ready: got %b required 1", in_ready);
        end
        n_checks++;
        if (swap !== 1'b0 || e_out !== '0 || shamt !== '0 || f_big !== '0 || f_small !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: swap=%b e_out=%h shamt=%0d f_big=%h f_small=%h required all 0",
                     swap, e_out, shamt, f_big, f_small);
        end
        for (int i = 0; i < 12; i++) begin
            if (out_valid === 1'b1) seen++;
            tick();
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL midrst_no_valid: out_valid high %0d cycles required 0", seen);
        end
    endtask

    task automatic test_directed();
        accept(11'h3FF, 11'h3FF, 53'h10_0000_0000_0000, 53'h10_0000_0000_0000);
        collect("equal");
        accept(11'h400, 11'h3FF, 53'h10_0000_0000_0000, 53'h10_0000_0000_0001);
        collect("diff1");
        accept(11'h3FF, 11'h40B, 53'h10_0000_0000_0001, 53'h10_0000_0000_0000);
        collect("b_sticky");
        accept(11'h7FE, 11'h001, 53'h1A_BCDE_F012_3456, 53'h10_0000_0000_0000);
        collect("clamp");
        accept(11'h7FE, 11'h001, 53'h1A_BCDE_F012_3456, 53'h0);
        collect("clamp_zero");
        accept(11'h000, 11'h7FF, 53'h1F_FFFF_FFFF_FFFF, 53'h10_0000_0000_0000);
        collect("extremes");
        accept(11'h010, 11'h000, 53'h10_0000_0000_0000, 53'h1F_FFFF_FFFF_FFFF);
        collect("diff16");
    endtask

    task automatic test_backpressure();
        int   c = 1;
        int   bad = 0;
        exp_t e;
        accept(11'h405, 11'h400, 53'h15_5555_5555_5555, 53'h1A_AAAA_AAAA_AAAB);
        while (!out_valid && c < 20) begin
            tick();
            c++;
        end
        e = model(11'h405, 11'h400, 53'h15_5555_5555_5555, 53'h1A_AAAA_AAAA_AAAB);
        if (sb_q.size() > 0) void'(sb_q.pop_front());
        ea = 11'h123; eb = 11'h456; fa = 53'h11_1111_1111_1111; fb = 53'h1E_EEEE_EEEE_EEEE;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || f_small !== e.f_small ||
                f_big !== e.f_big || shamt !== e.shamt || e_out !== e.e_out || swap !== e.swap) bad++;
            tick();
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bp_hold: %0d unstable cycles required 0 (f_small=%h required %h)",
                     bad, f_small, e.f_small);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: in_ready=%b required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        sb_q.push_back(model(11'h123, 11'h456, 53'h11_1111_1111_1111, 53'h1E_EEEE_EEEE_EEEE));
        collect("bp_new");
    endtask

    task automatic test_back_to_back();
        logic [EW-1:0] a, b;
        logic [FW-1:0] pa, pb;
        for (int i = 0; i < 10; i++) begin
            a  = EW'($urandom_range(0, 2047));
            b  = (i % 2 == 0) ? EW'(int'(a) ^ $urandom_range(0, 63)) : EW'($urandom_range(0, 2047));
            pa = {1'b1, 20'($urandom), 32'($urandom)};
            pb = {1'b1, 20'($urandom), 32'($urandom)};
            accept(a, b, pa, pb);
            collect("b2b");
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ea = '0; eb = '0; fa = '0; fb = '0;
        test_reset();
        test_reset_mid_shift();
        test_directed();
        test_backpressure();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
